// File: rtl/uart_loopback_fifo_if.sv
// Byte stream bundle between uart_driver and the loopback FIFO.
//   rx_data/rx_valid : received byte, 1-cycle strobe (driver -> FIFO)
//   tx_data/tx_valid : byte to transmit, valid/ready handshake (FIFO -> driver)
//   tx_ready         : driver can accept a TX byte (driver -> FIFO)
// master = uart_driver side, slave = loopback FIFO side.
interface uart_loopback_fifo_if #(
    parameter int unsigned P_DATA_WIDTH = 8
);
    logic [P_DATA_WIDTH-1:0] rx_data;
    logic                    rx_valid;
    logic [P_DATA_WIDTH-1:0] tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/uart_loopback_fifo.sv
// Buffered UART echo: every received byte is queued and replayed in order
// to the TX user port under a valid/ready handshake.
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous reset, active-low
//   bus            rx byte strobe in, tx valid/ready out (slave modport)
//   o_fifo_count   entries stored, excluding the byte being offered on TX
//   o_fifo_empty   o_fifo_count == 0
//   o_fifo_full    o_fifo_count == P_FIFO_DEPTH
//   o_overflow     sticky flag: a received byte was dropped
//   i_overflow_clr 1-cycle pulse clearing o_overflow
module uart_loopback_fifo #(
    parameter int unsigned P_DATA_WIDTH = 8,
    parameter int unsigned P_FIFO_DEPTH = 16
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    uart_loopback_fifo_if.slave               bus,
    output logic [$clog2(P_FIFO_DEPTH):0]     o_fifo_count,
    output logic                              o_fifo_empty,
    output logic                              o_fifo_full,
    output logic                              o_overflow,
    input  logic                              i_overflow_clr
);
    localparam int unsigned L_DW = P_DATA_WIDTH;
    localparam int unsigned L_AW = $clog2(P_FIFO_DEPTH);
    localparam int unsigned L_CW = L_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_e;

    state_e            state_q;
    logic [L_DW-1:0]   mem_q [P_FIFO_DEPTH];
    logic [L_AW-1:0]   wr_ptr_q;
    logic [L_AW-1:0]   rd_ptr_q;
    logic [L_CW-1:0]   count_q;
    logic [L_CW-1:0]   count_d;
    logic [L_DW-1:0]   rd_data_q;
    logic [L_DW-1:0]   tx_data_q;
    logic              tx_valid_q;
    logic              empty_q;
    logic              full_q;
    logic              overflow_q;

    logic              has_data_c;
    logic              is_full_c;
    logic              rd_en_c;
    logic              wr_en_c;
    logic              ovf_set_c;

    // Read/write enables and next fill level.
    always_comb begin
        has_data_c = (count_q != '0);
        is_full_c  = (count_q == L_CW'(P_FIFO_DEPTH));
        rd_en_c    = has_data_c &&
                     ((state_q == ST_IDLE) || ((state_q == ST_SEND) && bus.tx_ready));
        // A full FIFO still accepts a byte when a slot frees on the same edge.
        wr_en_c    = bus.rx_valid && (!is_full_c || rd_en_c);
        ovf_set_c  = bus.rx_valid && !wr_en_c;
        count_d    = count_q;
        if (wr_en_c && !rd_en_c) begin
            count_d = count_q + L_CW'(1);
        end else if (rd_en_c && !wr_en_c) begin
            count_d = count_q - L_CW'(1);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

    // Pointers, level, flags. The read byte is captured at the read edge so a
    // same-edge write into the freed slot cannot corrupt it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr_q <= wr_ptr_q + L_AW'(1);
            end
            if (rd_en_c) begin
                rd_ptr_q  <= rd_ptr_q + L_AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == L_CW'(P_FIFO_DEPTH));
            // Set takes priority over clear.
            if (ovf_set_c) begin
                overflow_q <= 1'b1;
            end else if (i_overflow_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // TX FSM: IDLE -> LOAD -> SEND, back to LOAD on transfer if more data.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (has_data_c) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_data_q  <= rd_data_q;
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= has_data_c ? ST_LOAD : ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign o_fifo_count   = count_q;
    assign o_fifo_empty   = empty_q;
    assign o_fifo_full    = full_q;
    assign o_overflow     = overflow_q;
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Self-checking bench for uart_loopback_fifo: cycle table for the single-byte
// echo, directed sequences for burst/overflow/wrap/reset corners.
module tb_uart_loopback_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow;
    logic          overflow_clr;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_q [$];

    uart_loopback_fifo_if #(.P_DATA_WIDTH(DW)) bus_if ();

    uart_loopback_fifo #(
        .P_DATA_WIDTH(DW),
        .P_FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .bus            (bus_if.slave),
        .o_fifo_count   (fifo_count),
        .o_fifo_empty   (fifo_empty),
        .o_fifo_full    (fifo_full),
        .o_overflow     (overflow),
        .i_overflow_clr (overflow_clr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          rxv;
        logic [DW-1:0] rxd;
        logic          rdy;
        logic          clr;
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_count;
        logic          e_empty;
        logic          e_full;
        logic          e_ovf;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic chk_status(input string tag, input logic [CW-1:0] cnt, input logic emp,
                              input logic ful, input logic ovf);
        chk({tag, "_count"}, 32'(fifo_count), 32'(cnt));
        chk({tag, "_empty"}, 32'(fifo_empty), 32'(emp));
        chk({tag, "_full"},  32'(fifo_full),  32'(ful));
        chk({tag, "_ovf"},   32'(overflow),   32'(ovf));
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        tick();
        bus_if.rx_valid = 1'b0;
    endtask

    // Wait with a cycle bound for n transfers, then compare the streams.
    task automatic drain_and_compare(input string tag, input int n, input int bound);
        int c;
        c = 0;
        bus_if.tx_ready = 1'b1;
        while (got_q.size() < n && c < bound) begin
            tick();
            c++;
        end
        chk({tag, "_xfer_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        logic          hold;
        logic [DW-1:0] hold_d;

        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = '0;
        bus_if.tx_ready = 1'b0;
        overflow_clr    = 1'b0;

        // Transfer monitor plus hold-stability check on stalled cycles.
        fork
            forever begin
                @(posedge i_clk);
                if (i_rst && bus_if.tx_valid && bus_if.tx_ready) begin
                    got_q.push_back(bus_if.tx_data);
                end
                hold   = i_rst && bus_if.tx_valid && !bus_if.tx_ready;
                hold_d = bus_if.tx_data;
                @(negedge i_clk);
                if (hold && i_rst) begin
                    chk("hold_valid", 32'(bus_if.tx_valid), 32'd1);
                    chk("hold_data",  32'(bus_if.tx_data),  32'(hold_d));
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        chk("rst_valid", 32'(bus_if.tx_valid), 32'd0);
        chk("rst_data",  32'(bus_if.tx_data),  32'd0);
        chk_status("rst", 5'd0, 1'b1, 1'b0, 1'b0);
        i_rst = 1'b1;
        tick();

        // Test 1: single byte echo, table driven
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 2; i < 13; i++) begin
            vecs[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        end
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 15; i++) begin
            bus_if.rx_valid = vecs[i].rxv;
            bus_if.rx_data  = vecs[i].rxd;
            bus_if.tx_ready = vecs[i].rdy;
            overflow_clr    = vecs[i].clr;
            tick();
            chk($sformatf("t1_v%0d_valid", i), 32'(bus_if.tx_valid), 32'(vecs[i].e_valid));
            chk($sformatf("t1_v%0d_data", i),  32'(bus_if.tx_data),  32'(vecs[i].e_data));
            chk_status($sformatf("t1_v%0d", i), vecs[i].e_count, vecs[i].e_empty,
                       vecs[i].e_full, vecs[i].e_ovf);
        end
        bus_if.rx_valid = 1'b0;
        overflow_clr    = 1'b0;
        chk("t1_xfers", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("t1_byte", 32'(got_q[0]), 32'hA5);
        got_q.delete();

        // Test 2: burst into stalled TX, fill, overflow
        bus_if.tx_ready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            send_byte(8'(b));
            exp_q.push_back(8'(b));
        end
        chk("t2_valid", 32'(bus_if.tx_valid), 32'd1);
        chk("t2_data",  32'(bus_if.tx_data),  32'h00);
        chk_status("t2_16", 5'd15, 1'b0, 1'b0, 1'b0);
        send_byte(8'h10);
        exp_q.push_back(8'h10);
        chk_status("t2_17", 5'd16, 1'b0, 1'b1, 1'b0);
        send_byte(8'hEE);
        chk_status("t2_18", 5'd16, 1'b0, 1'b1, 1'b1);

        // Test 5: clear, then clear colliding with a new drop
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("t5_clr", 32'(overflow), 32'd0);
        overflow_clr = 1'b1;
        send_byte(8'hEF);
        overflow_clr = 1'b0;
        chk_status("t5_set_wins", 5'd16, 1'b0, 1'b1, 1'b1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("t5_clr2", 32'(overflow), 32'd0);

        // Test 3: write into full FIFO on the same edge as a read
        bus_if.tx_ready = 1'b1;
        send_byte(8'h11);
        exp_q.push_back(8'h11);
        chk_status("t3", 5'd16, 1'b0, 1'b1, 1'b0);
        chk("t3_valid", 32'(bus_if.tx_valid), 32'd0);
        drain_and_compare("t2", 18, 200);
        tick();
        chk_status("t2_end", 5'd0, 1'b1, 1'b0, 1'b0);
        got_q.delete();
        exp_q.delete();

        // Test 4: random data, random ready, pointer wrap
        begin
            bit wr_done;
            wr_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 40; i++) begin
                        logic [DW-1:0] d;
                        d = 8'($urandom_range(0, 255));
                        repeat ($urandom_range(2, 5)) tick();
                        exp_q.push_back(d);
                        send_byte(d);
                    end
                    wr_done = 1'b1;
                end
                begin
                    while (!wr_done) begin
                        bus_if.tx_ready = ($urandom_range(0, 2) != 0);
                        tick();
                    end
                end
            join
        end
        drain_and_compare("t4", 40, 300);
        chk("t4_ovf", 32'(overflow), 32'd0);
        got_q.delete();
        exp_q.delete();

        // Test 6: asynchronous reset mid-SEND
        bus_if.tx_ready = 1'b0;
        for (int b = 0; b < 6; b++) send_byte(8'h50 + 8'(b));
        chk("t6_pre_valid", 32'(bus_if.tx_valid), 32'd1);
        chk_status("t6_pre", 5'd5, 1'b0, 1'b0, 1'b0);
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus_if.tx_valid), 32'd0);
        chk_status("t6_rst", 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        i_rst = 1'b1;
        tick();
        got_q.delete();
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        drain_and_compare("t6", 1, 50);
        repeat (20) tick();
        chk("t6_no_stale", 32'(got_q.size()), 32'd1);
        chk_status("t6_end", 5'd0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
